// File: rtl/result_writeback_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : result_writeback_if
// Brief  : Avalon-MM write-only bus bundle used by the result writeback block
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface result_writeback_if;
  logic [31:0] address;
  logic        write;
  logic [63:0] writedata;
  logic        waitrequest;

  modport master (
    output address,
    output write,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output waitrequest
  );
endinterface : result_writeback_if
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : result_writeback
// Brief  : Captures DEPTH MAC result lanes and writes them out as Avalon-MM
//          beats, one lane per accepted write.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module result_writeback #(
  parameter int          DEPTH      = 8,
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'd16
) (
  input  wire logic                            clk,
  input  wire logic                            rst_n,
  input  wire logic                            clr,
  input  wire logic                            start,
  input  wire logic                            mac_done,
  input  wire logic [DEPTH*3*DATA_WIDTH-1:0]   results,
  result_writeback_if.master                   bus,
  output logic                                 busy,
  output logic                                 wb_done,
  output logic                                 start_err
);

  localparam int c_LANE_W = 3 * DATA_WIDTH;
  localparam int c_BUF_W  = DEPTH * c_LANE_W;
  localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_CAPTURE = 2'd1;
  localparam logic [1:0] c_ST_WRITE   = 2'd2;
  localparam logic [1:0] c_ST_DONE    = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_BUF_W-1:0]  r_buf;
  logic                r_start_err;

  logic                w_accept;
  logic                w_start_ok;
  logic [c_LANE_W-1:0] w_lane;
  logic [63:0]         w_lane_ext;
  logic [31:0]         w_address;
  logic                w_write;
  logic [63:0]         w_writedata;
  logic                w_busy;
  logic                w_wb_done;

  assign w_start_ok = start && mac_done;
  assign w_accept   = (r_state == c_ST_WRITE) && !bus.waitrequest;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; clr wins over everything else in every state
  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_start_ok) w_next_state = c_ST_CAPTURE;
        end
        c_ST_CAPTURE: begin
          w_next_state = c_ST_WRITE;
        end
        c_ST_WRITE: begin
          if (w_accept && (r_idx == c_LAST_IDX)) w_next_state = c_ST_DONE;
        end
        c_ST_DONE: begin
          if (w_start_ok) w_next_state = c_ST_CAPTURE;
        end
        default: begin
          w_next_state = c_ST_IDLE;
        end
      endcase
    end
  end

  // Lane index: reset in CAPTURE, stepped on each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clr || (r_state == c_ST_CAPTURE)) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Result snapshot, taken only in the single CAPTURE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (r_state == c_ST_CAPTURE) begin
      r_buf <= results;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_err <= 1'b0;
    end else if (clr) begin
      r_start_err <= 1'b0;
    end else if ((r_state == c_ST_IDLE) && start && !mac_done) begin
      r_start_err <= 1'b1;
    end
  end

  assign w_lane = r_buf[32'(r_idx) * c_LANE_W +: c_LANE_W];

  generate
    if (c_LANE_W < 64) begin : g_pad
      assign w_lane_ext = {{(64 - c_LANE_W){1'b0}}, w_lane};
    end else begin : g_nopad
      assign w_lane_ext = w_lane[63:0];
    end
  endgenerate

  // Outputs decode straight from state so reset drops write without a clock
  always_comb begin
    w_address   = BASE_ADDR;
    w_write     = 1'b0;
    w_writedata = 64'd0;
    w_busy      = 1'b0;
    w_wb_done   = 1'b0;
    case (r_state)
      c_ST_CAPTURE: begin
        w_busy = 1'b1;
      end
      c_ST_WRITE: begin
        w_busy      = 1'b1;
        w_write     = 1'b1;
        w_address   = BASE_ADDR + 32'(r_idx);
        w_writedata = w_lane_ext;
      end
      c_ST_DONE: begin
        w_wb_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign bus.address   = w_address;
  assign bus.write     = w_write;
  assign bus.writedata = w_writedata;
  assign busy          = w_busy;
  assign wb_done       = w_wb_done;
  assign start_err     = r_start_err;

endmodule : result_writeback
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_result_writeback
// Brief  : Directed self-checking bench for result_writeback (DEPTH=8, DW=8)
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_writeback;

  localparam int c_DEPTH  = 8;
  localparam int c_DW     = 8;
  localparam int c_LANE_W = 3 * c_DW;

  logic                          CLOCK_50;
  logic                          rst_n;
  logic                          clr;
  logic                          start;
  logic                          mac_done;
  logic [c_DEPTH*c_LANE_W-1:0]   results;
  logic                          busy;
  logic                          wb_done;
  logic                          start_err;

  int n_checks;
  int n_errors;
  int r_cycles;

  result_writeback_if bus_if ();

  result_writeback #(
    .DEPTH      (c_DEPTH),
    .DATA_WIDTH (c_DW),
    .BASE_ADDR  (32'd16)
  ) dut (
    .clk       (CLOCK_50),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .mac_done  (mac_done),
    .results   (results),
    .bus       (bus_if.master),
    .busy      (busy),
    .wb_done   (wb_done),
    .start_err (start_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] lane_val(input int k);
    return 64'(k) * 64'h01_0101;
  endfunction

  function automatic logic [c_DEPTH*c_LANE_W-1:0] ramp_results();
    logic [c_DEPTH*c_LANE_W-1:0] v;
    v = '0;
    for (int i = 0; i < c_DEPTH; i++) v[i*c_LANE_W +: c_LANE_W] = c_LANE_W'(lane_val(i));
    return v;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_write"},     64'(bus_if.write),   64'd0);
    chk({tag, "_address"},   64'(bus_if.address), 64'd16);
    chk({tag, "_writedata"}, bus_if.writedata,    64'd0);
    chk({tag, "_busy"},      64'(busy),           64'd0);
  endtask

  // Start + capture; leaves the bench at the negedge of the CAPTURE cycle
  task automatic kick_off(input string tag);
    start    = 1'b1;
    mac_done = 1'b1;
    r_cycles = 0;
    @(negedge CLOCK_50);
    r_cycles++;
    start = 1'b0;
    chk({tag, "_capture_busy"},  64'(busy),         64'd1);
    chk({tag, "_capture_write"}, 64'(bus_if.write), 64'd0);
  endtask

  task automatic beat_check(input string tag, input int k);
    chk($sformatf("%s_b%0d_write", tag, k),   64'(bus_if.write),   64'd1);
    chk($sformatf("%s_b%0d_address", tag, k), 64'(bus_if.address), 64'(16 + k));
    chk($sformatf("%s_b%0d_data", tag, k),    bus_if.writedata,    lane_val(k));
  endtask

  // Full writeback; optional stall on one beat and optional results corruption
  task automatic do_writeback(input string tag, input int stall_beat, input int stall_cycles,
                              input bit corrupt, input int exp_cycles);
    int stalls;
    kick_off(tag);
    for (int k = 0; k < c_DEPTH; k++) begin
      stalls = (k == stall_beat) ? stall_cycles : 0;
      for (int s = 0; s <= stalls; s++) begin
        @(negedge CLOCK_50);
        r_cycles++;
        if (corrupt && k == 0 && s == 0) results = '1;
        beat_check(tag, k);
        waitrequest_set(s < stalls);
        start = (k == 3);
      end
    end
    @(negedge CLOCK_50);
    r_cycles++;
    start = 1'b0;
    waitrequest_set(1'b0);
    chk({tag, "_done"},        64'(wb_done),      64'd1);
    chk({tag, "_done_write"},  64'(bus_if.write), 64'd0);
    chk({tag, "_done_busy"},   64'(busy),         64'd0);
    chk({tag, "_done_cycles"}, 64'(r_cycles),     64'(exp_cycles));
  endtask

  task automatic waitrequest_set(input bit v);
    bus_if.waitrequest = v;
  endtask

  // Start and run zero-wait beats up to (and observing) beat n
  task automatic advance_to_beat(input string tag, input int n);
    kick_off(tag);
    for (int k = 0; k <= n; k++) begin
      @(negedge CLOCK_50);
      beat_check(tag, k);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    start    = 1'b0;
    mac_done = 1'b0;
    results  = ramp_results();
    bus_if.waitrequest = 1'b0;

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk_idle_outputs("reset");
    chk("reset_done", 64'(wb_done),   64'd0);
    chk("reset_err",  64'(start_err), 64'd0);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    chk_idle_outputs("post_reset");

    // Zero-wait writeback: DONE on cycle 10 after start
    do_writeback("zw", -1, 0, 1'b0, 10);
    @(negedge CLOCK_50);
    chk("done_hold", 64'(wb_done), 64'd1);

    // Rewrite from DONE with 3 stall cycles on beat 2
    do_writeback("bp", 2, 3, 1'b0, 13);

    // clr leaves DONE
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    chk("clr_done", 64'(wb_done), 64'd0);
    chk_idle_outputs("clr_idle");

    // Early start with mac_done low
    mac_done = 1'b0;
    start    = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("early_err", 64'(start_err), 64'd1);
    chk_idle_outputs("early_a");
    repeat (3) @(negedge CLOCK_50);
    chk_idle_outputs("early_b");
    chk("early_err_sticky", 64'(start_err), 64'd1);
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    chk("early_err_clr", 64'(start_err), 64'd0);

    // Capture isolation
    do_writeback("iso", -1, 0, 1'b1, 10);
    results = ramp_results();
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;

    // Asynchronous reset during a stalled beat 4
    advance_to_beat("rst", 4);
    bus_if.waitrequest = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_done", 64'(wb_done), 64'd0);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    bus_if.waitrequest = 1'b0;
    @(negedge CLOCK_50);
    chk_idle_outputs("rst_release");
    do_writeback("after_rst", -1, 0, 1'b0, 10);

    // clr during beat 5 abandons the beat even with waitrequest high
    clr = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    advance_to_beat("clrw", 5);
    clr = 1'b1;
    bus_if.waitrequest = 1'b1;
    @(negedge CLOCK_50);
    clr = 1'b0;
    bus_if.waitrequest = 1'b0;
    chk_idle_outputs("clrw_idle");
    chk("clrw_done", 64'(wb_done), 64'd0);
    repeat (3) @(negedge CLOCK_50);
    chk_idle_outputs("clrw_quiet");

    // Full write then rewrite from DONE
    do_writeback("rw1", -1, 0, 1'b0, 10);
    do_writeback("rw2", -1, 0, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_result_writeback
`default_nettype wire

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of MAC result lanes written back.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: MAC operand width; result lane width is 3*DATA_WIDTH.
REQ-003 SHALL have parameter BASE_ADDR, default 32'd16: word address of result lane 0.
REQ-004 SHALL have port clk, input, 1: single clock domain; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous return to IDLE; clears the done and error flags.
REQ-007 SHALL have port start, input, 1: single-cycle request to capture and write back results.
REQ-008 SHALL have port mac_done, input, 1: MAC completion flag; results are valid only while it is high.
REQ-009 SHALL have port results, input, DEPTH*3*DATA_WIDTH: flattened MAC outputs, lane i at bits [i*3*DATA_WIDTH +: 3*DATA_WIDTH].
REQ-010 SHALL have port address, output, 32: Avalon-MM word address.
REQ-011 SHALL have port write, output, 1: Avalon-MM write request.
REQ-012 SHALL have port writedata, output, 64: Avalon-MM write data.
REQ-013 SHALL have port waitrequest, input, 1: Avalon-MM slave stall.
REQ-014 SHALL have port busy, output, 1: high in CAPTURE or WRITE.
REQ-015 SHALL have port wb_done, output, 1: high in DONE.
REQ-016 SHALL have port start_err, output, 1: sticky; set when start is seen in IDLE while mac_done is low.

Function
REQ-017 SHALL implement four states: IDLE, CAPTURE, WRITE and DONE.
REQ-018 SHALL move from IDLE to CAPTURE when start and mac_done are both high; in IDLE, start with mac_done low SHALL set start_err and the block SHALL remain in IDLE.
REQ-019 SHALL, in CAPTURE (exactly one cycle), latch all DEPTH lanes of results into an internal buffer, set the lane index to 0, and go to WRITE.
REQ-020 SHALL, in WRITE, assert write=1, address=BASE_ADDR+index and writedata={zero-extend to 64 bits, buffer[index]}.
REQ-021 SHALL hold address, write and writedata stable while waitrequest=1.
REQ-022 SHALL treat a beat as accepted on a cycle with write=1 and waitrequest=0; on acceptance the index SHALL increment, and the block SHALL go to DONE after the beat with index=DEPTH-1.
REQ-023 SHALL take no fewer than DEPTH+1 cycles from start to the first DONE cycle with zero-wait writes; each waitrequest cycle SHALL add one cycle.
REQ-024 SHALL drive write=0 in IDLE, CAPTURE and DONE, with address=BASE_ADDR and writedata=0 in those states.
REQ-025 SHALL stay in DONE until clr is asserted, or until start is asserted with mac_done high, which SHALL go to CAPTURE (rewrite).
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL give clr priority over start in every state.
REQ-028 SHALL, on clr during WRITE, drop write on the next edge, regardless of waitrequest, and go to IDLE; the beat in flight is abandoned.
REQ-029 SHALL make the buffer immune to changes on results after CAPTURE; written data SHALL equal the values sampled in CAPTURE.
REQ-030 SHALL wrap the address modulo 2^32 on overflow.

Reset
REQ-031 SHALL, on rst_n=0, immediately and asynchronously set state=IDLE, index=0, write=0, address=BASE_ADDR, writedata=0, busy=0, wb_done=0 and start_err=0.
REQ-032 SHALL clear the buffer to 0 on reset.
REQ-033 SHALL, on reset asserted mid-WRITE, deassert write in the same cycle without waiting for a clock edge.
REQ-034 SHALL take no action on the first clock edge after rst_n deasserts, unless start is high.

Verification
REQ-035 Zero-wait writeback: DEPTH=8, results lane i = i*24'h010101, pulse start with mac_done=1 -> writes to addresses 16..23 with data 0, 24'h010101, ... 24'h070707 (zero-extended), one per cycle; wb_done high on cycle 10 after start.
REQ-036 Backpressure: waitrequest=1 for 3 cycles on beat 2 -> address 18 and writedata held for all 4 cycles; 8 writes total; DONE 3 cycles later than REQ-035.
REQ-037 Early start: start with mac_done=0 -> start_err=1, write never asserted, busy=0; a later clr clears start_err.
REQ-038 Capture isolation: change results to all-ones the cycle after CAPTURE -> written data still equals the originally captured values.
REQ-039 Reset mid-write: drop rst_n during beat 4 while waitrequest=1 -> write=0 asynchronously, outputs at reset values; after release with a new start, a full 8-beat writeback starts again at address 16.
REQ-040 Clear and restart: clr during beat 5 -> IDLE next cycle with no further writes; start in DONE with mac_done=1 -> complete rewrite of all 8 lanes.
